// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 14-bit binary to 4-digit BCD, shift-and-add-3, one bit/clk.
// Optional leading-zero blanking with BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       units,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands,
  output logic [3:0]       blank
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [3:0]       LAST  = 4'(WIDTH - 1);

  state_t             state;
  state_t             state_n;
  logic [3:0]         cnt;
  logic [WIDTH-1:0]   bin;
  logic [15:0]        acc;
  logic               ovf_sh;
  logic               over;
  logic [15:0]        acc_adj;
  logic [WIDTH+15:0]  shifted;

  function automatic logic [3:0] add3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign over = value > MAX_V;

  // corrected nibble is at most 12, so no carry leaves it
  assign acc_adj = {
    add3(acc[15:12]),
    add3(acc[11:8]),
    add3(acc[7:4]),
    add3(acc[3:0])
  };

  assign shifted = {acc_adj, bin} << 1;

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (cnt == LAST) state_n = LOAD;
      LOAD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = state != IDLE;

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt    <= '0;
      bin    <= '0;
      acc    <= '0;
      ovf_sh <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            bin    <= over ? MAX_V : value;
            ovf_sh <= over;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          acc <= shifted[WIDTH+15:WIDTH];
          bin <= shifted[WIDTH-1:0];
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // result registers move only at LOAD so the display never
  // sees partial values
  always_ff @(posedge CLK) begin
    if (reset) begin
      done      <= 1'b0;
      ovf       <= 1'b0;
      units     <= '0;
      tens      <= '0;
      hundreds  <= '0;
      thousands <= '0;
    end else begin
      done <= 1'b0;
      if (state == LOAD) begin
        done      <= 1'b1;
        ovf       <= ovf_sh;
        units     <= acc[3:0];
        tens      <= acc[7:4];
        hundreds  <= acc[11:8];
        thousands <= acc[15:12];
      end
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [3:0] blank_n;
  logic       z3;
  logic       z2;
  logic       z1;

  assign z3 = acc[15:12] == 4'd0;
  assign z2 = z3 && (acc[11:8] == 4'd0);
  assign z1 = z2 && (acc[7:4] == 4'd0);

  assign blank_n = {z3, z2, z1, 1'b0};

  always_ff @(posedge CLK) begin
    if (reset)              blank <= '0;
    else if (state == LOAD) blank <= blank_n;
  end
`else
  assign blank = 4'b0000;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed vector table plus corner sequences.
// Blank expectations follow BIN2BCD_BLANK_EN.
module tb_bin2bcd_seq;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] value;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  units;
  logic [3:0]  tens;
  logic [3:0]  hundreds;
  logic [3:0]  thousands;
  logic [3:0]  blank;

  bin2bcd_seq dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .value     (value),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .units     (units),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .blank     (blank)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [13:0] v;
    logic [15:0] bcd;
    logic        ov;
    logic [3:0]  blk;
  } vec_t;

  vec_t tbl[13];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] exp_blank(
    input logic [3:0] b
  );
`ifdef BIN2BCD_BLANK_EN
    return b;
`else
    return 4'b0000 & b;
`endif
  endfunction

  function automatic logic [15:0] digits;
    return {thousands, hundreds, tens, units};
  endfunction

  task automatic convert(input logic [13:0] v);
    int lat;
    int busy_bad;
    lat      = -1;
    busy_bad = 0;
    start = 1'b1;
    value = v;
    step();
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_bad++;
    end
    chk("latency", lat, 15);
    chk("busy_during", busy_bad, 0);
    chk("busy_at_done", {31'd0, busy}, 0);
  endtask

  task automatic chk_out(
    input string       nm,
    input logic [15:0] bcd,
    input logic        ov,
    input logic [3:0]  blk
  );
    chk({nm, "_digits"}, digits(), bcd);
    chk({nm, "_ovf"}, ovf, ov);
    chk({nm, "_blank"}, blank, exp_blank(blk));
  endtask

  initial begin
    logic [15:0] mb;
    logic [3:0]  mk;
    int          m;
    int          seen;

    tbl[0]  = '{14'd1234,  16'h1234, 1'b0, 4'b0000};
    tbl[1]  = '{14'd0,     16'h0000, 1'b0, 4'b1110};
    tbl[2]  = '{14'd9999,  16'h9999, 1'b0, 4'b0000};
    tbl[3]  = '{14'd12000, 16'h9999, 1'b1, 4'b0000};
    tbl[4]  = '{14'd16383, 16'h9999, 1'b1, 4'b0000};
    tbl[5]  = '{14'd7,     16'h0007, 1'b0, 4'b1110};
    tbl[6]  = '{14'd45,    16'h0045, 1'b0, 4'b1100};
    tbl[7]  = '{14'd800,   16'h0800, 1'b0, 4'b1000};
    tbl[8]  = '{14'd10,    16'h0010, 1'b0, 4'b1100};
    tbl[9]  = '{14'd100,   16'h0100, 1'b0, 4'b1000};
    tbl[10] = '{14'd1000,  16'h1000, 1'b0, 4'b0000};
    tbl[11] = '{14'd10000, 16'h9999, 1'b1, 4'b0000};
    tbl[12] = '{14'd5809,  16'h5809, 1'b0, 4'b0000};

    reset = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_out("rst", 16'h0000, 1'b0, 4'b0000);
    reset = 1'b0;
    step();

    foreach (tbl[i]) begin
      convert(tbl[i].v);
      chk_out($sformatf("vec%0d", i),
              tbl[i].bcd, tbl[i].ov, tbl[i].blk);
    end

    // start pulses during SHIFT and LOAD are dropped
    start = 1'b1;
    value = 14'd45;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    value = 14'd800;
    step();
    start = 1'b0;
    repeat (11) step();
    chk("e14_busy", busy, 1);
    chk("e14_done", done, 0);
    start = 1'b1;
    step();
    chk("e15_done", done, 1);
    chk("e15_busy", busy, 0);
    chk_out("ign", 16'h0045, 1'b0, 4'b1100);
    step();
    chk("e16_busy", busy, 1);
    chk("e16_done", done, 0);
    start = 1'b0;
    seen = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done) begin
        seen = i;
        break;
      end
    end
    chk("e16_latency", seen, 15);
    chk_out("e16", 16'h0800, 1'b0, 4'b1000);

    // reset mid-conversion abandons it
    start = 1'b1;
    value = 14'd9876;
    step();
    start = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    step();
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk_out("mid", 16'h0000, 1'b0, 4'b0000);
    reset = 1'b0;
    seen = 0;
    repeat (25) begin
      step();
      if (done || busy) seen++;
    end
    chk("mid_no_done", seen, 0);
    chk("mid_hold", digits(), 16'h0000);

    // reset wins over start
    reset = 1'b1;
    start = 1'b1;
    value = 14'd5;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("rs_busy", busy, 0);
    step();
    chk("rs_busy2", busy, 0);
    chk("rs_done", done, 0);

    convert(14'd321);
    chk_out("recov", 16'h0321, 1'b0, 4'b1000);

    // strided sweep against a decimal reference
    for (int v = 0; v < 16384; v += 97) begin
      m  = (v > 9999) ? 9999 : v;
      mb = {4'(m / 1000), 4'((m / 100) % 10),
            4'((m / 10) % 10), 4'(m % 10)};
      mk = {m < 1000, m < 100, m < 10, 1'b0};
      convert(14'(v));
      chk_out($sformatf("sw%0d", v), mb,
              v > 9999, mk);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
